// File: rtl/axi_lite_apb_bridge.sv
// AXI4-Lite slave to APB master bridge, one outstanding transfer, PCLK domain.
// Define APB_TIMEOUT_EN to bound ACCESS wait states with an SLVERR response.
module axi_lite_apb_bridge #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [31:0]       WDATA,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    state_t            state;
    logic              prio;
    logic              wr_cand;
    logic              rd_cand;
    logic              grant_w;
    logic              grant_r;
    logic              timeout;
    logic              err_resp;
    logic [ADDR_W-1:0] align_mask;

    assign align_mask = ~ADDR_W'(3);
    assign wr_cand    = AWVALID && WVALID;
    assign rd_cand    = ARVALID;

    // prio=0 favours write; it flips on every grant so contention alternates
    assign grant_w = PRESETn && (state == IDLE) && wr_cand && (!rd_cand || !prio);
    assign grant_r = PRESETn && (state == IDLE) && rd_cand && (!wr_cand || prio);

    assign AWREADY = grant_w;
    assign WREADY  = grant_w;
    assign ARREADY = grant_r;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // a timeout (no PREADY) always reports SLVERR
    assign err_resp = PSLVERR || !PREADY;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            prio    <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            BVALID  <= 1'b0;
            BRESP   <= OKAY;
            RVALID  <= 1'b0;
            RRESP   <= OKAY;
            RDATA   <= '0;
`ifdef APB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_w) begin
                        PADDR  <= AWADDR & align_mask;
                        PWDATA <= WDATA;
                        PWRITE <= 1'b1;
                        PSEL   <= 1'b1;
                        prio   <= ~prio;
                        state  <= SETUP;
                    end else if (grant_r) begin
                        PADDR  <= ARADDR & align_mask;
                        PWDATA <= '0;
                        PWRITE <= 1'b0;
                        PSEL   <= 1'b1;
                        prio   <= ~prio;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY || timeout) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        state   <= RESP;
                        if (PWRITE) begin
                            BVALID <= 1'b1;
                            BRESP  <= err_resp ? SLVERR : OKAY;
                        end else begin
                            RVALID <= 1'b1;
                            RRESP  <= err_resp ? SLVERR : OKAY;
                            RDATA  <= PREADY ? PRDATA : 32'h0;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if ((BVALID && BREADY) || (RVALID && RREADY)) begin
                        BVALID <= 1'b0;
                        RVALID <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Directed bench for axi_lite_apb_bridge: vector table plus hand sequences
// for arbitration, response back-pressure, timeout and async reset.
module tb_axi_lite_apb_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b1;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    always #5 PCLK = ~PCLK;

    axi_lite_apb_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // APB slave: PREADY after 'waits' ACCESS cycles unless stuck
    int          waits = 0;
    int          wcnt;
    logic [31:0] s_prdata = '0;
    logic        s_err = 1'b0;
    logic        stuck = 1'b0;

    assign PREADY  = PSEL && PENABLE && !stuck && (wcnt >= waits);
    assign PRDATA  = s_prdata;
    assign PSLVERR = s_err;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) wcnt <= 0;
        else if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    int errs = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    function automatic logic [107:0] all_out();
        return {AWREADY, WREADY, ARREADY, BVALID, BRESP, RVALID, RRESP,
                RDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA};
    endfunction

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          nwait;
        bit          err;
        logic [31:0] exp_paddr;
        logic [31:0] exp_pwdata;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic do_txn(input vec_t v, input string tag);
        int          lat;
        bit          stable;
        bit          rdy_bad;
        bit          ph1;
        bit          ph2;
        logic [1:0]  resp;
        logic [31:0] rd;
        lat = -1; stable = 1; rdy_bad = 0; ph1 = 0; ph2 = 0;
        resp = '0; rd = '0;
        waits = v.nwait; s_prdata = v.prdata; s_err = v.err;
        tick();
        if (v.wr) begin
            AWADDR = v.addr; WDATA = v.wdata; AWVALID = 1; WVALID = 1;
        end else begin
            ARADDR = v.addr; ARVALID = 1;
        end
        #1;
        check({tag, ".grant"}, {AWREADY, WREADY, ARREADY},
              v.wr ? 3'b110 : 3'b001);
        for (int c = 1; c < 200 && lat < 0; c++) begin
            tick();
            AWVALID = 0; WVALID = 0; ARVALID = 0;
            if (c == 1) ph1 = PSEL && !PENABLE;
            if (c == 2) ph2 = PSEL && PENABLE;
            if (PSEL && (PADDR !== v.exp_paddr || PWDATA !== v.exp_pwdata ||
                         PWRITE !== v.wr)) stable = 0;
            if (AWREADY || WREADY || ARREADY) rdy_bad = 1;
            if (v.wr ? BVALID : RVALID) begin
                lat = c;
                resp = v.wr ? BRESP : RRESP;
                rd = RDATA;
            end
        end
        check({tag, ".setup_c1"}, ph1, 1'b1);
        check({tag, ".access_c2"}, ph2, 1'b1);
        check({tag, ".latency"}, lat, v.exp_lat);
        check({tag, ".apb_stable"}, stable, 1'b1);
        check({tag, ".ready_outside_idle"}, rdy_bad, 1'b0);
        check({tag, ".resp"}, resp, v.exp_resp);
        if (!v.wr) check({tag, ".rdata"}, rd, v.exp_rdata);
        tick();
        check({tag, ".done"}, {BVALID, RVALID, PSEL, PENABLE}, 4'b0);
    endtask

    initial begin
        logic [23:0] ord;
        int          g;
        int          cnt;
        int          lat;
        bit          bad;

        vecs[0] = '{1'b1, 32'h0000_0004, 32'h0000_0001, 32'h0, 0, 1'b0,
                    32'h0000_0004, 32'h0000_0001, 2'b00, 32'h0, 3};
        vecs[1] = '{1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678, 3, 1'b0,
                    32'h0000_0000, 32'h0, 2'b00, 32'h1234_5678, 6};
        vecs[2] = '{1'b1, 32'h0000_0013, 32'hDEAD_BEEF, 32'h0, 1, 1'b1,
                    32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 32'h0, 4};
        vecs[3] = '{1'b0, 32'h0000_0008, 32'h0, 32'h0BAD_F00D, 0, 1'b1,
                    32'h0000_0008, 32'h0, 2'b10, 32'h0BAD_F00D, 3};
        vecs[4] = '{1'b0, 32'hFFFF_FFFE, 32'h0, 32'hA5A5_5A5A, 2, 1'b0,
                    32'hFFFF_FFFC, 32'h0, 2'b00, 32'hA5A5_5A5A, 5};
        vecs[5] = '{1'b1, 32'h0000_0100, 32'h0, 32'h0, 0, 1'b0,
                    32'h0000_0100, 32'h0, 2'b00, 32'h0, 3};

        // reset: requests pending, yet every output must stay 0
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        #12;
        check("reset.outputs", all_out(), 108'h0);
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        tick();
        PRESETn = 1;

        // contention from reset: write, read, write
        waits = 0; s_err = 0; s_prdata = 32'h0;
        ord = '0; g = 0; bad = 0;
        tick();
        AWADDR = 32'h20; WDATA = 32'h77; ARADDR = 32'h24;
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        for (int c = 0; c < 60 && g < 3; c++) begin
            #1;
            if (AWREADY && WREADY && !ARREADY) begin
                ord = {ord[15:0], 8'h57}; g++;
            end else if (ARREADY && !AWREADY && !WREADY) begin
                ord = {ord[15:0], 8'h52}; g++;
            end
            if ((AWREADY || WREADY || ARREADY) && (PSEL || BVALID || RVALID))
                bad = 1;
            tick();
        end
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        for (int c = 0; c < 20 && !BVALID; c++) tick();
        tick();
        check("prio.order", ord, 24'h575257);
        check("prio.ready_outside_idle", bad, 1'b0);
        check("prio.idle", {PSEL, BVALID, RVALID}, 3'b0);

        foreach (vecs[i]) do_txn(vecs[i], $sformatf("vec%0d", i));

        // read error with RREADY held low for 5 cycles
        waits = 0; s_err = 1; s_prdata = 32'hCAFE_0001;
        tick();
        ARADDR = 32'h30; ARVALID = 1; RREADY = 0;
        tick();
        ARVALID = 0;
        for (int c = 0; c < 20 && !RVALID; c++) tick();
        cnt = 0;
        for (int c = 0; c < 20 && RVALID; c++) begin
            if (RRESP == 2'b10 && RDATA == 32'hCAFE_0001) cnt++;
            tick();
            if (c == 4) RREADY = 1;
        end
        RREADY = 1; s_err = 0;
        check("bp.rvalid_cycles", cnt, 6);
        check("bp.idle", {RVALID, PSEL, PENABLE}, 3'b0);

        // PREADY stuck low
        stuck = 1; s_prdata = 32'h5555_AAAA; lat = -1;
        tick();
        ARADDR = 32'h40; ARVALID = 1;
        #1;
        check("stuck.grant", ARREADY, 1'b1);
        for (int c = 1; c < 120 && lat < 0; c++) begin
            tick();
            ARVALID = 0;
            if (RVALID) lat = c;
        end
`ifdef APB_TIMEOUT_EN
        check("timeout.latency", lat, 18);
        check("timeout.rresp", RRESP, 2'b10);
        check("timeout.rdata", RDATA, 32'h0);
        tick();
        check("timeout.done", {RVALID, PSEL}, 2'b0);
        stuck = 0;
`else
        check("stuck.no_resp", lat, -1);
        check("stuck.in_access", {PSEL, PENABLE}, 2'b11);
        PRESETn = 0;
        #1;
        check("stuck.reset", all_out(), 108'h0);
        tick();
        tick();
        PRESETn = 1;
        stuck = 0;
`endif

        // unaligned write, reset pulsed during ACCESS
        stuck = 1;
        tick();
        AWADDR = 32'h13; WDATA = 32'hA5A5; AWVALID = 1; WVALID = 1;
        tick();
        AWVALID = 0; WVALID = 0;
        tick();
        check("rst.paddr", PADDR, 32'h10);
        check("rst.access", {PSEL, PENABLE, PWRITE}, 3'b111);
        #2;
        PRESETn = 0;
        #1;
        check("rst.async", all_out(), 108'h0);
        tick();
        tick();
        PRESETn = 1;
        stuck = 0;
        bad = 0;
        repeat (10) begin
            tick();
            if (BVALID || RVALID || PSEL) bad = 1;
        end
        check("rst.no_resp", bad, 1'b0);
        check("rst.after", all_out(), 108'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
